sdvig_ctrl: RTL and testbench

Controller and sequencer for an 8-bit LED shift register.
- Shares the register between manual button shifts and an automatic timed shifter.
- Sequences a mode FSM: manual, auto-left, auto-right, bounce.
- Sits between raw board buttons/switches and the LED bank; owns the register, the prescaler and the arbitration.

---
 rtl/sdvig_ctrl_if.sv | 23 ++
 rtl/sdvig_ctrl.sv | 130 +++++++++++++
 tb/tb_sdvig_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdvig_ctrl_if.sv
// Board-side signal bundle for sdvig_ctrl: raw active-low buttons, shift-in switches, LED outputs.
interface sdvig_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             w_button2;
  logic             w_button3;
  logic             w_button_mode;
  logic             switch0;
  logic             switch1;
  logic [WIDTH-1:0] diod;
  logic [1:0]       mode;
  logic             tick;

  modport master (
    output w_button2, w_button3, w_button_mode, switch0, switch1,
    input  diod, mode, tick
  );

  modport slave (
    input  w_button2, w_button3, w_button_mode, switch0, switch1,
    output diod, mode, tick
  );
endinterface

// File: rtl/sdvig_ctrl.sv
// LED shift-register controller: manual button shifts, prescaled auto-shift and bounce sequencing.
// Optional macro SDVIG_CTRL_ROTATE_EN makes tick-driven shifts rotate instead of using the switches.
//
// state  | meaning
// MANUAL | buttons only, prescaler held at 0
// AUTO_L | each tick shifts left
// AUTO_R | each tick shifts right
// BOUNCE | each tick shifts in dir; dir flips every WIDTH-1 ticks
module sdvig_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV   = 50000000
) (
  input logic         clk,
  input logic         reset,
  sdvig_ctrl_if.slave bus
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [SW-1:0] STEP_WRAP = SW'(WIDTH - 2);

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    AUTO_L = 2'd1,
    AUTO_R = 2'd2,
    BOUNCE = 2'd3
  } mode_t;

  mode_t            r_mode, w_mode_nxt;
  logic [2:0]       r_s1, r_s2, r_press;  // bit 0 button2, bit 1 button3, bit 2 mode
  logic [WIDTH-1:0] r_diod;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_tick, w_tick_nxt;
  logic             r_dir_r;
  logic [SW-1:0]    r_step;
  logic             w_shl, w_shr, w_tick_shift;
  logic             w_in_l, w_in_r;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_press <= '0;
    end else begin
      r_s1    <= ~{bus.w_button_mode, bus.w_button3, bus.w_button2};
      r_s2    <= r_s1;
      r_press <= r_s1 & ~r_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_mode <= MANUAL;
    else        r_mode <= w_mode_nxt;
  end

  always_comb begin
    w_mode_nxt = r_mode;
    if (r_press[2]) w_mode_nxt = mode_t'(r_mode + 2'd1);
  end

  // One register update per cycle: mode press > left button > right button > tick.
  always_comb begin
    w_shl        = 1'b0;
    w_shr        = 1'b0;
    w_tick_shift = 1'b0;
    if (!r_press[2]) begin
      if (r_press[1]) begin
        w_shl = 1'b1;
      end else if (r_press[0]) begin
        w_shr = 1'b1;
      end else if (r_tick) begin
        w_tick_shift = 1'b1;
        case (r_mode)
          AUTO_L:  w_shl = 1'b1;
          AUTO_R:  w_shr = 1'b1;
          BOUNCE:  begin
            w_shl = ~r_dir_r;
            w_shr = r_dir_r;
          end
          default: w_tick_shift = 1'b0;
        endcase
      end
    end
  end

`ifdef SDVIG_CTRL_ROTATE_EN
  assign w_in_l = w_tick_shift ? r_diod[WIDTH-1] : bus.switch0;
  assign w_in_r = w_tick_shift ? r_diod[0] : bus.switch1;
`else
  assign w_in_l = bus.switch0;
  assign w_in_r = bus.switch1;
`endif

  always_comb begin
    w_cnt_nxt = '0;
    if (!r_press[2] && r_mode != MANUAL && r_cnt != CNT_LAST) w_cnt_nxt = r_cnt + CW'(1);
  end

  assign w_tick_nxt = (w_mode_nxt != MANUAL) && (w_cnt_nxt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_diod  <= '0;
      r_cnt   <= '0;
      r_tick  <= 1'b0;
      r_dir_r <= 1'b0;
      r_step  <= '0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_tick <= w_tick_nxt;
      if (w_shl)      r_diod <= {r_diod[WIDTH-2:0], w_in_l};
      else if (w_shr) r_diod <= {w_in_r, r_diod[WIDTH-1:1]};
      if (r_press[2] && w_mode_nxt == BOUNCE) begin
        r_dir_r <= 1'b0;
        r_step  <= '0;
      end else if (w_tick_shift && r_mode == BOUNCE) begin
        if (r_step == STEP_WRAP) begin
          r_step  <= '0;
          r_dir_r <= ~r_dir_r;
        end else begin
          r_step <= r_step + SW'(1);
        end
      end
    end
  end

  assign bus.diod = r_diod;
  assign bus.mode = r_mode;
  assign bus.tick = r_tick;
endmodule

// File: tb/tb_sdvig_ctrl.sv
// Bench for sdvig_ctrl: directed vector table, hand-built corner sequences and random traffic
// checked every cycle against an event-level reference model.
module tb_sdvig_ctrl;
  localparam int WIDTH = 8;
  localparam int DIV   = 4;
`ifdef SDVIG_CTRL_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  sdvig_ctrl_if #(.WIDTH(WIDTH)) bus ();
  sdvig_ctrl #(.WIDTH(WIDTH), .DIV(DIV)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pin history per button, edges since last mode change, bounce tick count.
  logic [WIDTH-1:0] m_diod = '0;
  int m_mode = 0;
  int m_el   = 0;
  int m_nb   = 0;
  bit m_tick = 1'b0;
  bit h [3][3];

  function automatic logic [WIDTH-1:0] tick_l(logic [WIDTH-1:0] d, bit sw);
    return {d[WIDTH-2:0], (ROT ? d[WIDTH-1] : sw)};
  endfunction

  function automatic logic [WIDTH-1:0] tick_r(logic [WIDTH-1:0] d, bit sw);
    return {(ROT ? d[0] : sw), d[WIDTH-1:1]};
  endfunction

  task automatic model_edge();
    bit pins [3];
    bit pr [3];
    bit tick_ev;
    pins = '{bus.w_button2, bus.w_button3, bus.w_button_mode};
    if (!reset) begin
      m_diod = '0; m_mode = 0; m_el = 0; m_nb = 0; m_tick = 1'b0;
      for (int b = 0; b < 3; b++) h[b] = '{1'b1, 1'b1, 1'b1};
    end else begin
      for (int b = 0; b < 3; b++) begin
        pr[b]   = !h[b][1] && h[b][2];
        h[b][2] = h[b][1];
        h[b][1] = h[b][0];
        h[b][0] = pins[b];
      end
      tick_ev = m_tick;
      if (pr[2]) begin
        m_mode = (m_mode + 1) % 4;
        m_el   = 0;
        if (m_mode == 3) m_nb = 0;
      end else begin
        m_el++;
        if (pr[1])      m_diod = {m_diod[WIDTH-2:0], bus.switch0};
        else if (pr[0]) m_diod = {bus.switch1, m_diod[WIDTH-1:1]};
        else if (tick_ev) begin
          if (m_mode == 1) m_diod = tick_l(m_diod, bus.switch0);
          else if (m_mode == 2) m_diod = tick_r(m_diod, bus.switch1);
          else if (m_mode == 3) begin
            if (((m_nb / (WIDTH - 1)) % 2) == 0) m_diod = tick_l(m_diod, bus.switch0);
            else                                 m_diod = tick_r(m_diod, bus.switch1);
            m_nb++;
          end
        end
      end
      m_tick = (m_mode != 0) && ((m_el % DIV) == DIV - 1);
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("model_diod", 32'(bus.diod), 32'(m_diod));
    check("model_mode", 32'(bus.mode), 32'(m_mode));
    check("model_tick", 32'(bus.tick), 32'(m_tick));
  endtask

  task automatic set_pin(int btn, logic v);
    case (btn)
      0:       bus.w_button2 = v;
      1:       bus.w_button3 = v;
      default: bus.w_button_mode = v;
    endcase
  endtask

  task automatic press(int btn, int hold);
    set_pin(btn, 1'b0);
    repeat (hold) cycle();
    set_pin(btn, 1'b1);
    repeat (4) cycle();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) cycle();
    reset = 1'b1;
  endtask

  task automatic fast_modes(int n);
    for (int i = 0; i < n; i++) begin
      bus.w_button_mode = 1'b0; cycle();
      bus.w_button_mode = 1'b1; cycle();
    end
    repeat (3) cycle();
  endtask

  task automatic wait_tick();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2 * DIV + 4; i++) begin
      if (bus.tick === 1'b1) begin ok = 1'b1; break; end
      cycle();
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_tick: tick never rose, got 0, expected 1 at %0t", $time);
    end
  endtask

  // Leaves the bench one edge before a tick that coincides with a press pulse on btn.
  // The tick consumed on the way is a plain tick shift the caller accounts for.
  task automatic collide_prep(int btn);
    wait_tick();
    cycle();
    cycle();
    set_pin(btn, 1'b0); cycle();
    set_pin(btn, 1'b1); cycle();
    check("collide_tick_due", 32'(bus.tick), 32'd1);
  endtask

  typedef struct {
    int         btn;
    int         hold;
    bit         sw0;
    bit         sw1;
    logic [7:0] exp_diod;
  } vec_t;

  vec_t vt [8];

  initial begin
    logic [7:0] exp;
    logic [7:0] pat;

    bus.w_button2 = 1'b1; bus.w_button3 = 1'b1; bus.w_button_mode = 1'b1;
    bus.switch0 = 1'b0;   bus.switch1 = 1'b0;
    for (int b = 0; b < 3; b++) h[b] = '{1'b1, 1'b1, 1'b1};

    vt[0] = '{1, 1,  1'b1, 1'b0, 8'h01};
    vt[1] = '{1, 1,  1'b1, 1'b0, 8'h03};
    vt[2] = '{1, 2,  1'b1, 1'b0, 8'h07};
    vt[3] = '{0, 1,  1'b1, 1'b0, 8'h03};
    vt[4] = '{1, 20, 1'b1, 1'b0, 8'h07};
    vt[5] = '{0, 1,  1'b0, 1'b1, 8'h83};
    vt[6] = '{0, 5,  1'b0, 1'b1, 8'hC1};
    vt[7] = '{1, 1,  1'b0, 1'b0, 8'h82};

    // Reset hold and release
    repeat (3) cycle();
    reset = 1'b1;
    cycle();
    check("rst_diod", 32'(bus.diod), 32'h0);
    check("rst_mode", 32'(bus.mode), 32'h0);
    check("rst_tick", 32'(bus.tick), 32'h0);

    // Manual shifts from the vector table
    foreach (vt[i]) begin
      bus.switch0 = vt[i].sw0;
      bus.switch1 = vt[i].sw1;
      press(vt[i].btn, vt[i].hold);
      check("vec_diod", 32'(bus.diod), 32'(vt[i].exp_diod));
      check("vec_mode", 32'(bus.mode), 32'h0);
    end

    // Load A5, enter AUTO_L, then reset mid-operation
    pat = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      bus.switch0 = pat[i];
      press(1, 1);
    end
    check("load_a5", 32'(bus.diod), 32'hA5);
    press(2, 1);
    check("auto_l_mode", 32'(bus.mode), 32'h1);
    check("auto_l_a5", 32'(bus.diod), 32'hA5);
    reset = 1'b0;
    cycle();
    check("midrst_diod", 32'(bus.diod), 32'h0);
    check("midrst_mode", 32'(bus.mode), 32'h0);
    reset = 1'b1;

    // AUTO_L cadence
    bus.switch0 = 1'b1;
    press(2, 1);
    exp = 8'h00;
    for (int k = 0; k < 4; k++) begin
      wait_tick();
      cycle();
      exp = tick_l(exp, 1'b1);
      check("al_shift", 32'(bus.diod), 32'(exp));
      check("al_tick_low", 32'(bus.tick), 32'h0);
      repeat (2) begin
        cycle();
        check("al_hold", 32'(bus.diod), 32'(exp));
        check("al_tick_low", 32'(bus.tick), 32'h0);
      end
      cycle();
      check("al_period", 32'(bus.tick), 32'h1);
    end

    // BOUNCE sweep from 0
    do_reset();
    bus.switch0 = 1'b1; bus.switch1 = 1'b0;
    fast_modes(3);
    check("bounce_mode", 32'(bus.mode), 32'h3);
    check("bounce_start", 32'(bus.diod), 32'h0);
    exp = 8'h00;
    for (int k = 0; k < 15; k++) begin
      wait_tick();
      cycle();
      if (k < 7 || k == 14) exp = tick_l(exp, 1'b1);
      else                  exp = tick_r(exp, 1'b0);
      check("bounce_step", 32'(bus.diod), 32'(exp));
    end

    // AUTO_R: manual left on a tick cycle wins, then a mode press on a tick cycle
    do_reset();
    bus.switch0 = 1'b1; bus.switch1 = 1'b0;
    fast_modes(2);
    check("auto_r_mode", 32'(bus.mode), 32'h2);
    exp = 8'h00;
    collide_prep(1);
    exp = tick_r(exp, 1'b0);
    cycle();
    exp = {exp[6:0], 1'b1};
    check("collide_left_only", 32'(bus.diod), 32'(exp));
    repeat (3) cycle();
    check("collide_next_tick", 32'(bus.tick), 32'h1);
    cycle();
    exp = tick_r(exp, 1'b0);
    check("auto_r_shift", 32'(bus.diod), 32'(exp));
    collide_prep(2);
    exp = tick_r(exp, 1'b0);
    bus.switch1 = 1'b1;
    cycle();
    check("mode_collide_mode", 32'(bus.mode), 32'h3);
    check("mode_collide_noshift", 32'(bus.diod), 32'(exp));
    check("mode_collide_tick", 32'(bus.tick), 32'h0);
    cycle(); cycle();
    check("restart_no_tick", 32'(bus.tick), 32'h0);
    cycle();
    check("restart_tick", 32'(bus.tick), 32'h1);

    // AUTO_L from 81 with switch0=0: rotate or shift zeros depending on build
    do_reset();
    pat = 8'h81;
    for (int i = 7; i >= 0; i--) begin
      bus.switch0 = pat[i];
      press(1, 1);
    end
    check("load_81", 32'(bus.diod), 32'h81);
    bus.switch0 = 1'b0;
    press(2, 1);
    exp = 8'h81;
    for (int k = 0; k < 8; k++) begin
      wait_tick();
      cycle();
      exp = tick_l(exp, 1'b0);
      check("rot_step", 32'(bus.diod), 32'(exp));
    end

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      reset             = ($urandom_range(0, 299) != 0);
      bus.w_button2     = ($urandom_range(0, 7) != 0);
      bus.w_button3     = ($urandom_range(0, 7) != 0);
      bus.w_button_mode = ($urandom_range(0, 23) != 0);
      bus.switch0       = 1'($urandom_range(0, 1));
      bus.switch1       = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
